// File: rtl/bsw_job_sched.sv
// Job sequencer upstream of bsw_acc: gathers R/Q bases, runs the accelerator under a
// start/ready handshake with a stale-ready guard and timeout, and emits a tagged result.
module bsw_job_sched #(
    parameter int unsigned L         = 8,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned ALN_W    = 3 * L + 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_base,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_start,
    output logic [3*L-1:0]   acc_r,
    output logic [3*L-1:0]   acc_q,
    input  logic [ALN_W-1:0] acc_r_aln,
    input  logic [ALN_W-1:0] acc_q_aln,
    input  logic             acc_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALN_W-1:0] out_r_aln,
    output logic [ALN_W-1:0] out_q_aln,
    output logic             out_err,
    output logic [7:0]       out_job_id,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(L + 1);

    typedef enum logic [2:0] {StLoadR, StLoadQ, StStart, StWait, StOut} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   base_cnt_q, base_cnt_d;
    logic [15:0]        start_cnt_q, start_cnt_d;
    logic [15:0]        tmo_q, tmo_d;
    logic               armed_q, armed_d;
    logic               in_ready_q, in_ready_d;
    logic               acc_start_q, acc_start_d;
    logic [3*L-1:0]     acc_r_q, acc_r_d;
    logic [3*L-1:0]     acc_q_q, acc_q_d;
    logic               out_valid_q, out_valid_d;
    logic [ALN_W-1:0]   out_r_aln_q, out_r_aln_d;
    logic [ALN_W-1:0]   out_q_aln_q, out_q_aln_d;
    logic               out_err_q, out_err_d;
    logic [7:0]         out_job_id_q, out_job_id_d;
    logic               busy_q, busy_d;
    logic               accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        base_cnt_d   = base_cnt_q;
        start_cnt_d  = start_cnt_q;
        tmo_d        = tmo_q;
        armed_d      = armed_q;
        acc_r_d      = acc_r_q;
        acc_q_d      = acc_q_q;
        out_valid_d  = out_valid_q;
        out_r_aln_d  = out_r_aln_q;
        out_q_aln_d  = out_q_aln_q;
        out_err_d    = out_err_q;
        out_job_id_d = out_job_id_q;

        unique case (state_q)
            StLoadR: begin
                if (accept) begin
                    // First base lands in the MSBs.
                    for (int unsigned k = 0; k < L; k++) begin
                        if (base_cnt_q == CNT_W'(k)) acc_r_d[3*L-1-3*k -: 3] = in_base;
                    end
                    if (base_cnt_q == CNT_W'(L - 1)) begin
                        base_cnt_d = '0;
                        state_d    = StLoadQ;
                    end else begin
                        base_cnt_d = base_cnt_q + CNT_W'(1);
                    end
                end
            end
            StLoadQ: begin
                if (accept) begin
                    for (int unsigned k = 0; k < L; k++) begin
                        if (base_cnt_q == CNT_W'(k)) acc_q_d[3*L-1-3*k -: 3] = in_base;
                    end
                    if (base_cnt_q == CNT_W'(L - 1)) begin
                        base_cnt_d  = '0;
                        start_cnt_d = '0;
                        state_d     = StStart;
                    end else begin
                        base_cnt_d = base_cnt_q + CNT_W'(1);
                    end
                end
            end
            StStart: begin
                if (start_cnt_q == 16'(START_CYC - 1)) begin
                    tmo_d   = '0;
                    armed_d = 1'b0;
                    state_d = StWait;
                end else begin
                    start_cnt_d = start_cnt_q + 16'd1;
                end
            end
            StWait: begin
                tmo_d = tmo_q + 16'd1;
                // A ready already high at WAIT entry is stale until it has been seen low.
                if (!acc_ready) armed_d = 1'b1;
                if (armed_q && acc_ready) begin
                    out_r_aln_d = acc_r_aln;
                    out_q_aln_d = acc_q_aln;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    out_r_aln_d = '0;
                    out_q_aln_d = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    out_job_id_d = out_job_id_q + 8'd1;
                    state_d      = StLoadR;
                end
            end
            default: state_d = StLoadR;
        endcase

        in_ready_d  = (state_d == StLoadR) || (state_d == StLoadQ);
        acc_start_d = (state_d != StWait);
        busy_d      = !((state_d == StLoadR) && (base_cnt_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StLoadR;
            base_cnt_q   <= '0;
            start_cnt_q  <= '0;
            tmo_q        <= '0;
            armed_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            acc_start_q  <= 1'b1;
            acc_r_q      <= '0;
            acc_q_q      <= '0;
            out_valid_q  <= 1'b0;
            out_r_aln_q  <= '0;
            out_q_aln_q  <= '0;
            out_err_q    <= 1'b0;
            out_job_id_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_cnt_q   <= base_cnt_d;
            start_cnt_q  <= start_cnt_d;
            tmo_q        <= tmo_d;
            armed_q      <= armed_d;
            in_ready_q   <= in_ready_d;
            acc_start_q  <= acc_start_d;
            acc_r_q      <= acc_r_d;
            acc_q_q      <= acc_q_d;
            out_valid_q  <= out_valid_d;
            out_r_aln_q  <= out_r_aln_d;
            out_q_aln_q  <= out_q_aln_d;
            out_err_q    <= out_err_d;
            out_job_id_q <= out_job_id_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign acc_start  = acc_start_q;
    assign acc_r      = acc_r_q;
    assign acc_q      = acc_q_q;
    assign out_valid  = out_valid_q;
    assign out_r_aln  = out_r_aln_q;
    assign out_q_aln  = out_q_aln_q;
    assign out_err    = out_err_q;
    assign out_job_id = out_job_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bsw_job_sched.sv
// Self-checking bench for bsw_job_sched: directed jobs plus randomized jobs scored against
// a transaction-level model of loading, start hold, ready guard, timeout and job numbering.
module tb_bsw_job_sched;

    localparam int L       = 8;
    localparam int ALN_W   = 3 * L + 6;
    localparam int TIMEOUT = 255;
    localparam int PAT_N   = 300;

    logic             clk;
    logic             rst;
    logic [2:0]       in_base;
    logic             in_valid;
    logic             in_ready;
    logic             acc_start;
    logic [3*L-1:0]   acc_r;
    logic [3*L-1:0]   acc_q;
    logic [ALN_W-1:0] acc_r_aln;
    logic [ALN_W-1:0] acc_q_aln;
    logic             acc_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ALN_W-1:0] out_r_aln;
    logic [ALN_W-1:0] out_q_aln;
    logic             out_err;
    logic [7:0]       out_job_id;
    logic             busy;

    bsw_job_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_base    (in_base),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_start  (acc_start),
        .acc_r      (acc_r),
        .acc_q      (acc_q),
        .acc_r_aln  (acc_r_aln),
        .acc_q_aln  (acc_q_aln),
        .acc_ready  (acc_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r_aln  (out_r_aln),
        .out_q_aln  (out_q_aln),
        .out_err    (out_err),
        .out_job_id (out_job_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               checks;
    int               errors;
    int               exp_jid;
    logic [2:0]       rb [L];
    logic [2:0]       qb [L];
    bit               pat [PAT_N];
    bit               fixed_aln;
    logic [ALN_W-1:0] fix_r;
    logic [ALN_W-1:0] fix_q;
    int               hold_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture needs a low ready seen before some later high ready, within the WAIT budget.
    task automatic model_wait(output int n_wait, output bit cap);
        int z;
        z = -1;
        cap = 1'b0;
        n_wait = TIMEOUT;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (z < 0 && !pat[i]) z = i;
        end
        if (z >= 0) begin
            for (int j = z + 1; j < TIMEOUT; j++) begin
                if (pat[j] && !cap) begin
                    cap = 1'b1;
                    n_wait = j + 1;
                end
            end
        end
    endtask

    task automatic rand_job();
        int m;
        for (int k = 0; k < L; k++) begin
            rb[k] = 3'($urandom);
            qb[k] = 3'($urandom);
        end
        m = $urandom_range(0, 6);
        for (int i = 0; i < PAT_N; i++) pat[i] = (i < m) ? 1'($urandom) : (i != m);
        fixed_aln = 1'b0;
        hold_cyc = $urandom_range(0, 4);
    endtask

    task automatic run_job();
        int               n_wait;
        bit               cap;
        logic [3*L-1:0]   xr;
        logic [3*L-1:0]   xq;
        logic [ALN_W-1:0] er;
        logic [ALN_W-1:0] eq;
        logic [ALN_W-1:0] ar;
        logic [ALN_W-1:0] aq;
        for (int k = 0; k < L; k++) begin
            xr[3*L-1-3*k -: 3] = rb[k];
            xq[3*L-1-3*k -: 3] = qb[k];
        end
        model_wait(n_wait, cap);
        er = '0;
        eq = '0;

        for (int k = 0; k < 2 * L; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_base = 3'($urandom);
                @(negedge clk);
            end
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_base = (k < L) ? rb[k] : qb[k-L];
            @(negedge clk);
            in_valid = 1'b0;
            chk("busy_load", busy, 1);
        end

        chk("acc_r", acc_r, xr);
        chk("acc_q", acc_q, xq);
        chk("start_hold1", acc_start, 1);
        chk("in_ready_start", in_ready, 0);
        acc_ready = 1'($urandom);
        in_valid = 1'($urandom);
        in_base = 3'($urandom);
        @(negedge clk);
        chk("start_hold2", acc_start, 1);
        @(negedge clk);
        chk("start_drop", acc_start, 0);
        chk("acc_q_stable", acc_q, xq);

        for (int i = 0; i < n_wait; i++) begin
            if (i > 0) chk("wait_hold", {acc_start, out_valid}, 0);
            acc_ready = pat[i];
            ar = fixed_aln ? fix_r : ALN_W'({$urandom, $urandom});
            aq = fixed_aln ? fix_q : ALN_W'({$urandom, $urandom});
            acc_r_aln = ar;
            acc_q_aln = aq;
            in_valid = 1'($urandom);
            if (i == n_wait - 1 && cap) begin
                er = ar;
                eq = aq;
            end
            @(negedge clk);
        end
        acc_ready = 1'b0;

        chk("out_valid", out_valid, 1);
        chk("out_err", out_err, !cap);
        chk("out_r_aln", out_r_aln, er);
        chk("out_q_aln", out_q_aln, eq);
        chk("acc_start_out", acc_start, 1);
        chk("in_ready_out", in_ready, 0);
        chk("job_id", out_job_id, exp_jid);

        for (int h = 0; h < hold_cyc; h++) begin
            out_ready = 1'b0;
            in_valid = 1'($urandom);
            acc_r_aln = ALN_W'({$urandom, $urandom});
            @(negedge clk);
            chk("hold_stable", {out_valid, out_err, out_r_aln, out_q_aln[7:0], in_ready},
                {1'b1, !cap, er, eq[7:0], 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        exp_jid = (exp_jid + 1) % 256;
        chk("valid_drop", out_valid, 0);
        chk("job_id_inc", out_job_id, exp_jid);
        chk("in_ready_idle", in_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_acc_start"}, acc_start, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_job_id"}, out_job_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_acc_r"}, acc_r, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_jid = 0;
        rst = 1'b1;
        in_base = '0;
        in_valid = 1'b0;
        acc_ready = 1'b0;
        acc_r_aln = '0;
        acc_q_aln = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Ascending R, descending Q; ready rises 40 cycles into WAIT.
        for (int k = 0; k < L; k++) begin
            rb[k] = 3'(k);
            qb[k] = 3'(7 - k);
        end
        for (int i = 0; i < PAT_N; i++) pat[i] = (i >= 40);
        fixed_aln = 1'b1;
        fix_r = 30'o1234567012;
        fix_q = 30'o7654321076;
        hold_cyc = 0;
        run_job();

        // Stale ready at entry, low from 3, high again at 20.
        rand_job();
        for (int i = 0; i < PAT_N; i++) pat[i] = (i < 3) || (i >= 20);
        run_job();

        // Ready never rises: timeout.
        rand_job();
        for (int i = 0; i < PAT_N; i++) pat[i] = 1'b0;
        run_job();

        // Ready rises on the timeout cycle: capture wins.
        rand_job();
        for (int i = 0; i < PAT_N; i++) pat[i] = (i >= TIMEOUT - 1);
        run_job();

        // Consumer stalls 10 cycles.
        rand_job();
        hold_cyc = 10;
        run_job();

        // Random jobs through the job id wrap.
        while (exp_jid != 0) begin
            rand_job();
            run_job();
        end
        chk("job_id_wrapped", out_job_id, 0);

        // Reset after 3 R bases, then a clean job.
        rand_job();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_base = 3'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("partial_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midload_rst");
        exp_jid = 0;
        repeat (3) begin
            @(negedge clk);
            chk("no_out_after_rst", out_valid, 0);
        end
        run_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
